// File: rtl/spi_multi_adapter.sv
// SPI minion bridge to NCHAN val/rdy channels: per-channel outbound and inbound
// circular queues, round-robin inbound reads, saturating dropped-write counter.

module spi_multi_adapter_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  input  logic [W-1:0]             enq_data,
  input  logic                     deq_rdy,
  output logic [W-1:0]             deq_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          enq_fire;
  logic          deq_fire;

  assign enq_rdy  = count < CNTW'(DEPTH);
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_rdy & (count != '0);
  assign deq_data = mem[rp];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq_fire) wp <= wp + AW'(1);
      if (deq_fire) rp <= rp + AW'(1);
      if (enq_fire && !deq_fire)      count <= count + CNTW'(1);
      else if (!enq_fire && deq_fire) count <= count - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem[wp] <= enq_data;
  end

endmodule

module spi_multi_adapter #(
  parameter int unsigned PW    = 8,
  parameter int unsigned NCHAN = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_en,
  input  logic                         push_msg_val_wrt,
  input  logic                         push_msg_val_rd,
  input  logic [$clog2(NCHAN)+PW-1:0]  push_msg_data,
  input  logic                         pull_en,
  output logic                         pull_msg_val,
  output logic                         pull_msg_spc,
  output logic [$clog2(NCHAN)+PW-1:0]  pull_msg_data,
  input  logic [NCHAN*PW-1:0]          recv_msg,
  input  logic [NCHAN-1:0]             recv_val,
  output logic [NCHAN-1:0]             recv_rdy,
  output logic [NCHAN*PW-1:0]          send_msg,
  output logic [NCHAN-1:0]             send_val,
  input  logic [NCHAN-1:0]             send_rdy,
  output logic [7:0]                   err_count
);

  localparam int unsigned CW    = $clog2(NCHAN);
  localparam int unsigned NBITS = CW + PW;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

  logic [NCHAN-1:0] mc_wr;
  logic [NCHAN-1:0] mc_rdy;
  logic [NCHAN-1:0] cm_val;
  logic [NCHAN-1:0] cm_deq;
  logic [CNTW-1:0]  mc_cnt  [NCHAN];
  logic [CNTW-1:0]  cm_cnt  [NCHAN];
  logic [PW-1:0]    cm_head [NCHAN];
  logic [CW-1:0]    wr_chan;
  logic [PW-1:0]    wr_payload;
  logic [CW-1:0]    rr;
  logic [CW-1:0]    sel;
  logic [CW-1:0]    idx;
  logic             wr_ev;
  logic             rd_ev;
  logic             wr_drop;
  logic             found;

  assign wr_ev      = push_en & push_msg_val_wrt;
  assign rd_ev      = pull_en & push_msg_val_rd;
  assign wr_chan    = push_msg_data[NBITS-1 -: CW];
  assign wr_payload = push_msg_data[PW-1:0];

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    spi_multi_adapter_fifo #(.W(PW), .DEPTH(DEPTH)) u_mc_q (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (mc_wr[i]),
      .enq_rdy  (mc_rdy[i]),
      .enq_data (wr_payload),
      .deq_rdy  (send_rdy[i]),
      .deq_data (send_msg[i*PW +: PW]),
      .count    (mc_cnt[i])
    );
    spi_multi_adapter_fifo #(.W(PW), .DEPTH(DEPTH)) u_cm_q (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (recv_val[i]),
      .enq_rdy  (recv_rdy[i]),
      .enq_data (recv_msg[i*PW +: PW]),
      .deq_rdy  (cm_deq[i]),
      .deq_data (cm_head[i]),
      .count    (cm_cnt[i])
    );
    assign send_val[i] = mc_cnt[i] != '0;
    assign cm_val[i]   = cm_cnt[i] != '0;
  end

  // Write steering; out-of-range channels and full queues both drop.
  always_comb begin
    mc_wr        = '0;
    pull_msg_spc = 1'b1;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      mc_wr[i] = wr_ev && (32'(wr_chan) == i) && mc_rdy[i];
      if (32'(mc_cnt[i]) + (mc_wr[i] ? 32'd2 : 32'd0) >= DEPTH) pull_msg_spc = 1'b0;
    end
    wr_drop = wr_ev & ~(|mc_wr);
  end

  // Round-robin inbound selection starting at rr.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    idx    = '0;
    cm_deq = '0;
    for (int unsigned k = 0; k < NCHAN; k++) begin
      idx = CW'((32'(rr) + k) % NCHAN);
      if (!found && cm_val[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    pull_msg_val = rd_ev & found;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      cm_deq[i] = pull_msg_val && (32'(sel) == i);
    end
    pull_msg_data = pull_msg_val ? {sel, cm_head[sel]} : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr        <= '0;
      err_count <= '0;
    end else begin
      if (pull_msg_val) rr <= (32'(sel) == NCHAN - 1) ? '0 : sel + CW'(1);
      if (wr_drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_multi_adapter.sv
// Directed bench for spi_multi_adapter: a 4-channel instance for the main
// behaviour and a 3-channel instance for out-of-range writes and saturation.

module tb_spi_multi_adapter;

  logic        clk;
  logic        reset;

  logic        push_en, push_msg_val_wrt, push_msg_val_rd, pull_en;
  logic [9:0]  push_msg_data;
  logic        pull_msg_val, pull_msg_spc;
  logic [9:0]  pull_msg_data;
  logic [31:0] recv_msg;
  logic [3:0]  recv_val, recv_rdy;
  logic [31:0] send_msg;
  logic [3:0]  send_val, send_rdy;
  logic [7:0]  err_count;

  logic        push_en2, push_msg_val_wrt2, push_msg_val_rd2, pull_en2;
  logic [9:0]  push_msg_data2;
  logic        pull_msg_val2, pull_msg_spc2;
  logic [9:0]  pull_msg_data2;
  logic [23:0] recv_msg2;
  logic [2:0]  recv_val2, recv_rdy2;
  logic [23:0] send_msg2;
  logic [2:0]  send_val2, send_rdy2;
  logic [7:0]  err_count2;

  int checks;
  int failures;

  spi_multi_adapter #(.PW(8), .NCHAN(4), .DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .push_en          (push_en),
    .push_msg_val_wrt (push_msg_val_wrt),
    .push_msg_val_rd  (push_msg_val_rd),
    .push_msg_data    (push_msg_data),
    .pull_en          (pull_en),
    .pull_msg_val     (pull_msg_val),
    .pull_msg_spc     (pull_msg_spc),
    .pull_msg_data    (pull_msg_data),
    .recv_msg         (recv_msg),
    .recv_val         (recv_val),
    .recv_rdy         (recv_rdy),
    .send_msg         (send_msg),
    .send_val         (send_val),
    .send_rdy         (send_rdy),
    .err_count        (err_count)
  );

  spi_multi_adapter #(.PW(8), .NCHAN(3), .DEPTH(4)) dut3 (
    .clk              (clk),
    .reset            (reset),
    .push_en          (push_en2),
    .push_msg_val_wrt (push_msg_val_wrt2),
    .push_msg_val_rd  (push_msg_val_rd2),
    .push_msg_data    (push_msg_data2),
    .pull_en          (pull_en2),
    .pull_msg_val     (pull_msg_val2),
    .pull_msg_spc     (pull_msg_spc2),
    .pull_msg_data    (pull_msg_data2),
    .recv_msg         (recv_msg2),
    .recv_val         (recv_val2),
    .recv_rdy         (recv_rdy2),
    .send_msg         (send_msg2),
    .send_val         (send_val2),
    .send_rdy         (send_rdy2),
    .err_count        (err_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    push_en = 1'b0; push_msg_val_wrt = 1'b0; push_msg_val_rd = 1'b0; pull_en = 1'b0;
    push_msg_data = '0; recv_val = '0; send_rdy = '0;
  endtask

  task automatic write(input logic [9:0] data);
    push_en = 1'b1; push_msg_val_wrt = 1'b1; push_msg_data = data;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    idle_inputs();
    recv_msg = '0;
    push_en2 = 1'b0; push_msg_val_wrt2 = 1'b0; push_msg_val_rd2 = 1'b0; pull_en2 = 1'b0;
    push_msg_data2 = '0; recv_msg2 = '0; recv_val2 = '0; send_rdy2 = '0;

    // Reset state, with a read event asserted that must not show.
    @(negedge clk);
    pull_en = 1'b1; push_msg_val_rd = 1'b1;
    #1;
    check_eq("rst_send_val", 32'(send_val), 32'h0);
    check_eq("rst_recv_rdy", 32'(recv_rdy), 32'hF);
    check_eq("rst_pull_val", 32'(pull_msg_val), 32'h0);
    check_eq("rst_pull_data", 32'(pull_msg_data), 32'h0);
    check_eq("rst_spc", 32'(pull_msg_spc), 32'h1);
    check_eq("rst_err", 32'(err_count), 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    // Single write to channel 2, then drain it.
    write({2'd2, 8'hA5});
    #1 check_eq("w2_spc", 32'(pull_msg_spc), 32'h1);
    step();
    idle_inputs();
    #1;
    check_eq("w2_send_val", 32'(send_val), 32'h4);
    check_eq("w2_send_msg", 32'(send_msg[23:16]), 32'hA5);
    send_rdy = 4'b0100;
    step();
    send_rdy = '0;
    #1 check_eq("w2_drained", 32'(send_val), 32'h0);

    // Fill channel 1, watch space flag, overflow drop.
    for (int k = 0; k < 4; k++) begin
      write({2'd1, 8'(k + 1)});
      #1 check_eq($sformatf("fill_spc%0d", k), 32'(pull_msg_spc), (k >= 2) ? 32'h0 : 32'h1);
      step();
    end
    write({2'd1, 8'hEE});
    #1 check_eq("full_spc", 32'(pull_msg_spc), 32'h0);
    step();
    idle_inputs();
    #1;
    check_eq("ovf_err", 32'(err_count), 32'h1);
    check_eq("ovf_send_val", 32'(send_val), 32'h2);
    send_rdy = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1 check_eq($sformatf("drain1_%0d", k), 32'(send_msg[15:8]), 32'(k + 1));
      step();
    end
    send_rdy = '0;
    #1 check_eq("drain1_empty", 32'(send_val), 32'h0);

    // Round-robin reads from channels 0 and 3.
    recv_msg = 32'h2200_0011;
    recv_val = 4'b1001;
    step();
    recv_val = '0;
    pull_en = 1'b1; push_msg_val_rd = 1'b1;
    #1;
    check_eq("rd0_val", 32'(pull_msg_val), 32'h1);
    check_eq("rd0_data", 32'(pull_msg_data), 32'h011);
    step();
    #1;
    check_eq("rd1_val", 32'(pull_msg_val), 32'h1);
    check_eq("rd1_data", 32'(pull_msg_data), 32'h322);
    step();
    #1;
    check_eq("rd2_val", 32'(pull_msg_val), 32'h0);
    check_eq("rd2_data", 32'(pull_msg_data), 32'h0);
    idle_inputs();

    // Simultaneous write to ch0 and read from ch0.
    recv_msg = 32'h0000_0033;
    recv_val = 4'b0001;
    step();
    recv_val = '0;
    write({2'd0, 8'h44});
    pull_en = 1'b1; push_msg_val_rd = 1'b1;
    #1;
    check_eq("rw_pull_val", 32'(pull_msg_val), 32'h1);
    check_eq("rw_pull_data", 32'(pull_msg_data), 32'h033);
    step();
    idle_inputs();
    #1;
    check_eq("rw_send_val", 32'(send_val), 32'h1);
    check_eq("rw_send_msg", 32'(send_msg[7:0]), 32'h44);
    pull_en = 1'b1; push_msg_val_rd = 1'b1;
    #1 check_eq("rw_cm_empty", 32'(pull_msg_val), 32'h0);
    idle_inputs();

    // Fill everything, then pulse reset between edges.
    recv_msg = 32'h4433_2211;
    for (int k = 0; k < 4; k++) begin
      write({2'd0, 8'(8'h50 + k)});
      recv_val = 4'b1111;
      step();
    end
    idle_inputs();
    #1;
    check_eq("fill_spc", 32'(pull_msg_spc), 32'h0);
    check_eq("fill_err", 32'(err_count), 32'h2);
    check_eq("fill_recv_rdy", 32'(recv_rdy), 32'h0);
    pull_en = 1'b1; push_msg_val_rd = 1'b1;
    #1 check_eq("fill_pull_val", 32'(pull_msg_val), 32'h1);
    reset = 1'b0;
    #1;
    check_eq("pulse_send_val", 32'(send_val), 32'h0);
    check_eq("pulse_recv_rdy", 32'(recv_rdy), 32'hF);
    check_eq("pulse_spc", 32'(pull_msg_spc), 32'h1);
    check_eq("pulse_err", 32'(err_count), 32'h0);
    check_eq("pulse_pull_val", 32'(pull_msg_val), 32'h0);
    check_eq("pulse_pull_data", 32'(pull_msg_data), 32'h0);
    #1 reset = 1'b1;
    idle_inputs();
    step();
    #1 check_eq("post_rst_empty", 32'(send_val), 32'h0);
    write({2'd3, 8'h5A});
    step();
    idle_inputs();
    #1;
    check_eq("post_rst_val", 32'(send_val), 32'h8);
    check_eq("post_rst_msg", 32'(send_msg[31:24]), 32'h5A);

    // Three-channel instance: writes to channel 3 drop and saturate.
    push_en2 = 1'b1; push_msg_val_wrt2 = 1'b1; push_msg_data2 = {2'd3, 8'h77};
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("n3_err1", 32'(err_count2), 32'h1);
    check_eq("n3_no_send", 32'(send_val2), 32'h0);
    repeat (254) @(posedge clk);
    @(negedge clk);
    #1 check_eq("n3_err255", 32'(err_count2), 32'hFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 check_eq("n3_err_sat", 32'(err_count2), 32'hFF);
    push_msg_data2 = {2'd2, 8'h66};
    step();
    push_en2 = 1'b0; push_msg_val_wrt2 = 1'b0;
    #1;
    check_eq("n3_ok_err", 32'(err_count2), 32'hFF);
    check_eq("n3_ok_val", 32'(send_val2), 32'h4);
    check_eq("n3_ok_msg", 32'(send_msg2[23:16]), 32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
